// File: rtl/rx_check_module_pkg.sv
// Shared definitions for the receive-side port checker.
//   - Default switch geometry (port count, payload width).
//   - FSM state type and error-class bit positions.
package rx_check_module_pkg;

  localparam int PORT_NUB_TOTAL  = 16;
  localparam int DATA_WIDTH_DFLT = 16;

  // Frame length register width; covers MAX_LEN up to 255.
  localparam int LEN_W = 8;

  // Error-class positions inside err_code.
  localparam int ERR_ROUTE = 0;
  localparam int ERR_SRC   = 1;
  localparam int ERR_DATA  = 2;
  localparam int ERR_LONG  = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/rx_check_module_sat_counter.sv
// Saturating event counter: counts up by one per cycle with inc high and
// holds at all-ones instead of wrapping.
// Ports:
//   clk   in  1  rising-edge clock
//   rst_n in  1  asynchronous active-low reset (clears the count)
//   inc   in  1  count enable
//   q     out W  current count
module sat_counter
  import rx_check_module_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/rx_check_module.sv
// Receive-side checker for one switch output port. Watches frames (contiguous
// vaild runs) leaving the switch, checks routing, source stability, payload
// encoding and frame length, and keeps saturating statistics.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   vaild        word valid; a frame is one contiguous high run
//   rx_port      destination port carried with the word
//   tx_port      source port carried with the word
//   data_port    payload word, expected to be src*16 + PORT_ID
//   busy         high while a frame is being received
//   frame_done   one-cycle pulse once a frame has ended
//   frame_ok     qualifies frame_done: frame had no error
//   frame_cnt    frames completed (saturating)
//   word_cnt     words accepted (saturating)
//   err_cnt      frames with at least one error (saturating)
//   err_code     sticky error classes: [0] route [1] src [2] data [3] overlong
//   src_seen     bit s set once a frame from source s has completed
module rx_check_module
  import rx_check_module_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int MAX_LEN    = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int PORT_NUB   = PORT_NUB_TOTAL,
  parameter int WIDTH_SEL  = $clog2(PORT_NUB),
  parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vaild,
  input  logic [WIDTH_SEL-1:0]  rx_port,
  input  logic [WIDTH_SEL-1:0]  tx_port,
  input  logic [DATA_WIDTH-1:0] data_port,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  frame_ok,
  output logic [CNT_WIDTH-1:0]  frame_cnt,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic [3:0]            err_code,
  output logic [PORT_NUB-1:0]   src_seen
);

  localparam logic [WIDTH_SEL-1:0] PORT_SEL  = WIDTH_SEL'(PORT_ID);
  localparam logic [LEN_W-1:0]     MAX_LEN_L = LEN_W'(MAX_LEN);

  rx_state_e              state_q, state_d;
  logic [WIDTH_SEL-1:0]   src_q, src_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   frame_err_q, frame_err_d;
  logic [3:0]             err_code_q, err_code_d;
  logic [PORT_NUB-1:0]    src_seen_q, src_seen_d;

  logic                   first_word;
  logic [WIDTH_SEL-1:0]   cur_src;
  logic [3:0]             werr;
  logic                   frame_inc;
  logic                   err_inc;

  // Payload a correctly routed word from source s must carry, in DATA_WIDTH bits.
  function automatic logic [DATA_WIDTH-1:0] exp_data(input logic [WIDTH_SEL-1:0] s);
    logic [DATA_WIDTH-1:0] sx;
    sx = DATA_WIDTH'(s);
    return (sx << 4) + DATA_WIDTH'(PORT_ID);
  endfunction

  // Word checks. Outside RECV the word opens a frame, so its own tx_port is
  // the reference source and neither the source nor length check can fire.
  always_comb begin
    first_word       = (state_q != ST_RECV);
    cur_src          = first_word ? tx_port : src_q;
    werr             = '0;
    werr[ERR_ROUTE]  = (rx_port != PORT_SEL);
    werr[ERR_SRC]    = !first_word && (tx_port != src_q);
    werr[ERR_DATA]   = (data_port != exp_data(cur_src));
    werr[ERR_LONG]   = !first_word && (len_q >= MAX_LEN_L);
    if (!vaild) begin
      werr = '0;
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    len_d       = len_q;
    frame_err_d = frame_err_q;
    err_code_d  = err_code_q | werr;
    src_seen_d  = src_seen_q;
    frame_inc   = 1'b0;
    err_inc     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (vaild) begin
          src_d       = tx_port;
          len_d       = LEN_W'(1);
          frame_err_d = |werr;
          state_d     = ST_RECV;
        end
      end
      ST_RECV: begin
        if (vaild) begin
          // Length saturates at MAX_LEN; further words only raise overlong.
          if (len_q < MAX_LEN_L) begin
            len_d = len_q + LEN_W'(1);
          end
          frame_err_d = frame_err_q | (|werr);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        frame_inc          = 1'b1;
        err_inc            = frame_err_q;
        src_seen_d[src_q]  = 1'b1;
        frame_err_d        = 1'b0;
        len_d              = '0;
        state_d            = ST_IDLE;
        // A word here opens the next frame directly.
        if (vaild) begin
          src_d       = tx_port;
          len_d       = LEN_W'(1);
          frame_err_d = |werr;
          state_d     = ST_RECV;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      src_q       <= '0;
      len_q       <= '0;
      frame_err_q <= 1'b0;
      err_code_q  <= '0;
      src_seen_q  <= '0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      len_q       <= len_d;
      frame_err_q <= frame_err_d;
      err_code_q  <= err_code_d;
      src_seen_q  <= src_seen_d;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_frame_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (frame_inc),
    .q     (frame_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_word_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (vaild),
    .q     (word_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (err_inc),
    .q     (err_cnt)
  );

  assign busy       = (state_q == ST_RECV);
  assign frame_done = (state_q == ST_DONE);
  assign frame_ok   = frame_done && !frame_err_q;
  assign err_code   = err_code_q;
  assign src_seen   = src_seen_q;

endmodule

// File: tb/tb_rx_check_module.sv
module tb_rx_check_module;

  localparam int PORT_ID = 3;
  localparam int MAX_LEN = 4;
  localparam int CW      = 3;
  localparam int CMAX    = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vaild = 1'b0;
  logic [3:0]  rx_port = '0;
  logic [3:0]  tx_port = '0;
  logic [15:0] data_port = '0;
  logic        busy, frame_done, frame_ok;
  logic [CW-1:0] frame_cnt, word_cnt, err_cnt;
  logic [3:0]  err_code;
  logic [15:0] src_seen;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  rx_check_module #(
    .PORT_ID(PORT_ID), .MAX_LEN(MAX_LEN), .CNT_WIDTH(CW),
    .PORT_NUB(16), .WIDTH_SEL(4), .DATA_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .vaild(vaild), .rx_port(rx_port), .tx_port(tx_port),
    .data_port(data_port), .busy(busy), .frame_done(frame_done), .frame_ok(frame_ok),
    .frame_cnt(frame_cnt), .word_cnt(word_cnt), .err_cnt(err_cnt),
    .err_code(err_code), .src_seen(src_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frames are tracked from the vaild history: a frame ends on a 1->0 step of
  // vaild, and its statistics land one cycle after the following idle cycle.
  int          m_frame, m_word, m_err;
  logic [3:0]  m_code;
  logic [15:0] m_seen;
  bit          pv, ppv;
  int          cur_src, cur_len, pend_src;
  bit          cur_err, pend_err;

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  task automatic model_reset();
    m_frame = 0; m_word = 0; m_err = 0; m_code = '0; m_seen = '0;
    pv = 0; ppv = 0; cur_src = 0; cur_len = 0; cur_err = 0; pend_src = 0; pend_err = 0;
  endtask

  task automatic model_edge();
    bit first;
    bit e;
    if (ppv && !pv) begin
      m_frame = sat(m_frame + 1);
      if (pend_err) m_err = sat(m_err + 1);
      m_seen[pend_src] = 1'b1;
    end
    if (vaild) begin
      m_word = sat(m_word + 1);
      first = !pv;
      if (first) begin
        cur_src = int'(tx_port); cur_len = 1; cur_err = 0;
      end else begin
        cur_len++;
      end
      e = 0;
      if (int'(rx_port) != PORT_ID) begin m_code[0] = 1'b1; e = 1; end
      if (!first && int'(tx_port) != cur_src) begin m_code[1] = 1'b1; e = 1; end
      if (data_port != 16'(cur_src * 16 + PORT_ID)) begin m_code[2] = 1'b1; e = 1; end
      if (cur_len > MAX_LEN) begin m_code[3] = 1'b1; e = 1; end
      if (e) cur_err = 1;
    end else if (pv) begin
      pend_src = cur_src;
      pend_err = cur_err;
    end
    ppv = pv;
    pv  = vaild;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("busy",       32'(busy),       32'(pv));
      chk("frame_done", 32'(frame_done), 32'(ppv && !pv));
      chk("frame_ok",   32'(frame_ok),   32'(ppv && !pv && !pend_err));
      chk("frame_cnt",  32'(frame_cnt),  32'(m_frame));
      chk("word_cnt",   32'(word_cnt),   32'(m_word));
      chk("err_cnt",    32'(err_cnt),    32'(m_err));
      chk("err_code",   32'(err_code),   32'(m_code));
      chk("src_seen",   32'(src_seen),   32'(m_seen));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v, input logic [3:0] rx, input logic [3:0] tx,
                       input logic [15:0] d);
    @(negedge clk); #1;
    vaild = v; rx_port = rx; tx_port = tx; data_port = d;
  endtask

  task automatic word(input logic [3:0] rx, input logic [3:0] tx, input logic [15:0] d);
    drive(1'b1, rx, tx, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'hF, 4'hA, 16'hDEAD);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0; vaild = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("reset_err_code",  32'(err_code),  32'd0);
    #1 rst_n = 1'b1;

    // Good 4-word frame from source 5 (length exactly MAX_LEN).
    for (int i = 0; i < 4; i++) word(4'd3, 4'd5, 16'h0053);
    idle(1);
    @(negedge clk);
    chk("good_done", 32'(frame_done), 32'd1);
    chk("good_ok",   32'(frame_ok),   32'd1);
    @(negedge clk);
    chk("good_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("good_word_cnt",  32'(word_cnt),  32'd4);
    chk("good_err_cnt",   32'(err_cnt),   32'd0);
    chk("good_src_seen",  32'(src_seen),  32'h0020);
    chk("good_model_word", 32'(m_word), 32'd4);

    // Misrouted middle word.
    do_reset();
    word(4'd3, 4'd5, 16'h0053);
    word(4'd2, 4'd5, 16'h0053);
    word(4'd3, 4'd5, 16'h0053);
    idle(1);
    @(negedge clk);
    chk("route_ok", 32'(frame_ok), 32'd0);
    @(negedge clk);
    chk("route_err_cnt",  32'(err_cnt),  32'd1);
    chk("route_err_code", 32'(err_code), 32'h1);
    chk("route_model_code", 32'(m_code), 32'h1);

    // Source change (also wrong data for latched src 5), then zero payload.
    do_reset();
    word(4'd3, 4'd5, 16'h0053);
    word(4'd3, 4'd6, 16'h0063);
    word(4'd3, 4'd5, 16'h0000);
    idle(1);
    @(negedge clk);
    chk("src_ok", 32'(frame_ok), 32'd0);
    @(negedge clk);
    chk("src_err_code", 32'(err_code), 32'h6);
    chk("src_err_cnt",  32'(err_cnt),  32'd1);

    // Overlong 5-word frame, one idle cycle, then a good 1-word frame.
    do_reset();
    for (int i = 0; i < 5; i++) word(4'd3, 4'd5, 16'h0053);
    idle(1);
    word(4'd3, 4'd7, 16'h0073);
    idle(1);
    @(negedge clk);
    chk("b2b_ok", 32'(frame_ok), 32'd1);
    @(negedge clk);
    chk("long_err_code",  32'(err_code),  32'h8);
    chk("long_frame_cnt", 32'(frame_cnt), 32'd2);
    chk("long_err_cnt",   32'(err_cnt),   32'd1);
    chk("long_word_cnt",  32'(word_cnt),  32'd6);
    chk("long_src_seen",  32'(src_seen),  32'h00A0);
    chk("long_model_frame", 32'(m_frame), 32'd2);

    // Reset in the middle of a frame discards it.
    do_reset();
    word(4'd3, 4'd5, 16'h0053);
    word(4'd3, 4'd5, 16'h0053);
    @(negedge clk); #1;
    rst_n = 1'b0; vaild = 1'b0;
    @(negedge clk);
    chk("midrst_word_cnt", 32'(word_cnt), 32'd0);
    chk("midrst_busy",     32'(busy),     32'd0);
    #1 rst_n = 1'b1;
    word(4'd3, 4'd2, 16'h0023);
    idle(1);
    @(negedge clk);
    @(negedge clk);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd1);
    chk("midrst_word_cnt2", 32'(word_cnt),  32'd1);
    chk("midrst_src_seen",  32'(src_seen),  32'h0004);

    // Nine 1-word frames saturate the 3-bit counters at 7.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      word(4'd3, 4'(i), 16'(i * 16 + 3));
      idle(1);
    end
    @(negedge clk);
    @(negedge clk);
    chk("sat_frame_cnt", 32'(frame_cnt), 32'd7);
    chk("sat_word_cnt",  32'(word_cnt),  32'd7);
    chk("sat_src_seen",  32'(src_seen),  32'h01FF);
    chk("sat_model_frame", 32'(m_frame), 32'd7);

    idle(2);
    @(negedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
